// File: rtl/wb_mem_responder_pkg.sv
// rtl/wb_mem_responder_pkg.sv - shared Wishbone widths and response-entry type
//
// Purpose: constants and types shared by the bus logic and the memory
// responder. A response entry carries the read data to return and the number
// of cycles still to wait before it may be acknowledged.
// Ports: none (package).

package wb_mem_responder_pkg;

    localparam int WB_DATA_W  = 32;
    localparam int WB_SEL_W   = WB_DATA_W / 8;
    localparam int RESP_LAT_W = 4;

    typedef struct packed {
        logic [WB_DATA_W-1:0]  data;
        logic [RESP_LAT_W-1:0] lat;
    } resp_entry_t;

    // Lane-masked write: keep old bytes where sel is clear.
    function automatic logic [WB_DATA_W-1:0] merge_bytes(
        input logic [WB_DATA_W-1:0] old_word,
        input logic [WB_DATA_W-1:0] new_word,
        input logic [WB_SEL_W-1:0]  sel
    );
        logic [WB_DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < WB_SEL_W; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_resp_queue.sv
// rtl/wb_resp_queue.sv - in-order response FIFO with per-entry latency countdown
//
// Purpose: holds one entry per accepted request, in acceptance order. Every
// stored entry's latency field counts down by one each cycle until it reaches
// zero; the owner decides when the head is due and pops it.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (clears counters too)
//   push, entry   write one entry at the tail (ignored when full)
//   pop           remove the head entry (ignored when empty)
//   flush         discard every entry; takes priority over push/pop
//   head          current head entry (meaningful only when !empty)
//   full, empty   registered occupancy status

module wb_resp_queue
    import wb_mem_responder_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  resp_entry_t entry,
    input  logic        pop,
    input  logic        flush,
    output resp_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    resp_entry_t      slots [QDEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(QDEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            // Free-running countdown on every slot; stale slots are harmless
            // because they are overwritten on push before being read.
            for (int i = 0; i < QDEPTH; i++) begin
                if (slots[i].lat != '0) begin
                    slots[i].lat <= slots[i].lat - 1'b1;
                end
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    slots[wr_ptr] <= entry;
                    wr_ptr        <= next_ptr(wr_ptr);
                end
                if (pop_ok) begin
                    rd_ptr <= next_ptr(rd_ptr);
                end
                case ({push_ok, pop_ok})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/wb_mem_responder.sv
// rtl/wb_mem_responder.sv - Wishbone B4 pipelined memory slave with fixed latency
//
// Purpose: word memory behind a pipelined Wishbone slave. Requests are
// accepted one per cycle, executed against memory at the acceptance edge and
// acknowledged in order exactly LATENCY cycles later via a response queue.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset
//   wb_adr_i          byte address (word index taken from the low bits)
//   wb_dat_i, wb_sel_i write data and byte-lane enables
//   wb_we_i           1 = write, 0 = read
//   wb_stb_i, wb_cyc_i strobe and bus cycle
//   wb_ack_o, wb_dat_o one-cycle acknowledge and its read data (0 otherwise)
//   wb_stall_o        request offered this cycle is refused

module wb_mem_responder
    import wb_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [WB_DATA_W-1:0] wb_dat_i,
    output logic [WB_DATA_W-1:0] wb_dat_o,
    input  logic                 wb_we_i,
    input  logic [WB_SEL_W-1:0]  wb_sel_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    output logic                 wb_ack_o,
    output logic                 wb_stall_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WB_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]        idx;
    logic                 ready;
    logic                 accept;
    logic                 q_full;
    logic                 q_empty;
    resp_entry_t          q_head;
    resp_entry_t          q_entry;
    logic                 unused_adr_bits;

    assign idx             = wb_adr_i[AW+1:2];
    assign unused_adr_bits = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

    // Cleared asynchronously by reset, so stall is forced high while reset is
    // held and drops at the first clock edge after release.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

    // Registered occupancy only: a pop in this cycle does not free a slot for
    // a request offered in the same cycle.
    assign wb_stall_o = !ready || q_full;
    assign accept     = wb_cyc_i && wb_stb_i && !wb_stall_o;

    // No reset on the array: contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && wb_we_i) begin
            mem[idx] <= merge_bytes(mem[idx], wb_dat_i, wb_sel_i);
        end
    end

    // Read data is the pre-edge word, i.e. it reflects every earlier write.
    assign q_entry.data = wb_we_i ? '0 : mem[idx];
    assign q_entry.lat  = RESP_LAT_W'(LATENCY - 1);

    wb_resp_queue #(
        .QDEPTH(QDEPTH)
    ) u_resp_queue (
        .clk   (clk_i),
        .rst_n (rst_i),
        .push  (accept),
        .entry (q_entry),
        .pop   (wb_ack_o),
        .flush (!wb_cyc_i),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Gated by cyc so a cycle being abandoned never sees an ack; the queue is
    // flushed at that same edge.
    assign wb_ack_o = wb_cyc_i && !q_empty && (q_head.lat == '0);
    assign wb_dat_o = wb_ack_o ? q_head.data : '0;

endmodule
